pulse_cdc_scheduler: RTL and testbench
======================================

PULSE_CDC_SCHEDULER -- requirements
Module: pulse_cdc_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of clka-domain requesters sharing one toggle-handshake channel (2..16).
REQ-002 Parameter SYNC_STAGES, default 2: flops on the ack_tgl synchronizer (>=2).
REQ-003 Parameter TIMEOUT_CYC, default 255: clka cycles in WAIT before timeout_err sets (1..65535).
REQ-004 clka  in  1  clock; the only clock of the block.
REQ-005 rstna  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  1 = new grants allowed; 0 = finish in-flight transfer, no new grant.
REQ-007 req  in  NREQ  level request per requester, held until its done pulse.
REQ-008 gnt  out  NREQ  one-hot, one-cycle pulse when that requester's transfer launches.
REQ-009 done  out  NREQ  one-hot, one-cycle pulse when the far side acknowledges.
REQ-010 tx_tgl  out  1  request toggle to clkb domain; flips once per launch.
REQ-011 tx_id  out  ID_W  index of requester owning the channel; stable from launch until done.
REQ-012 ack_tgl  in  1  acknowledge toggle from clkb domain, asynchronous to clka.
REQ-013 busy  out  1  high in WAIT and COOL.
REQ-014 timeout_err  out  1  sticky timeout flag.
REQ-015 err_clr  in  1  single-cycle clear of timeout_err.

Function
REQ-016 FSM states IDLE, WAIT, COOL; one transfer in flight at any time.
REQ-017 IDLE: en=1 and any req bit set at edge N -> at edge N+1: gnt[k]=1 for one cycle, tx_tgl inverts, tx_id=k, state WAIT.
REQ-018 Arbitration round-robin: search starts at (last granted index + 1) mod NREQ; after reset, search starts at index 0.
REQ-019 A req bit deasserted before sampling in IDLE receives no grant; req changes during WAIT/COOL are ignored.
REQ-020 ack_tgl passes through SYNC_STAGES flops; completion condition is synchronized ack level == tx_tgl.
REQ-021 WAIT: completion detected at edge N -> at edge N+1: done[tx_id]=1 for one cycle, state COOL.
REQ-022 COOL lasts exactly one cycle, then IDLE; minimum spacing between gnt pulses is therefore 3 cycles plus round-trip.
REQ-023 Timeout counter: 16 bits, cleared on launch, increments each WAIT cycle, saturates; reaching TIMEOUT_CYC sets timeout_err; state remains WAIT.
REQ-024 err_clr clears timeout_err; if set and clear occur in the same cycle, set wins.
REQ-025 en deasserted in WAIT: transfer completes normally, then stays IDLE until en=1.
REQ-026 Completion and a new request in the same cycle: the request is served only after COOL.
REQ-027 ID_W = max(1, clog2(NREQ)); tx_id width follows.

Reset
REQ-028 rstna low: state IDLE, gnt=0, done=0, tx_tgl=0, tx_id=0, busy=0, timeout_err=0, counter=0, RR pointer=0, synchronizer flops=0.
REQ-029 Reset mid-transfer abandons it with no done pulse; the clkb-side partner SHALL be reset concurrently so its ack toggle returns to 0.
REQ-030 Reset deassertion is synchronized to clka externally; all flops use the same asynchronous reset.

Structure
REQ-031 Shared package holds the FSM state enum, ID_W computation function and default parameter constants.
REQ-032 One sub-module, sync_bit: SYNC_STAGES-deep single-bit synchronizer with asynchronous active-low reset, instantiated for ack_tgl.
REQ-033 No combinational path from any input to any output; all outputs registered.

Verification
REQ-034 Single request: req=4'b0010, far side echoes tx_tgl after 5 clka -> gnt=4'b0010 one cycle, tx_tgl 0->1, tx_id=1, done=4'b0010 after sync latency, busy low after COOL.
REQ-035 Fairness: req=4'b1111 held, each dropped on its done -> grant order 0,1,2,3; then req=4'b1001 -> order 0,3,0,3.
REQ-036 Timeout: TIMEOUT_CYC=10, ack never returns -> timeout_err high after 10 WAIT cycles, state WAIT; err_clr pulse while counter saturated -> stays set; late ack -> done pulse, err_clr then clears.
REQ-037 en gating: en=0 during WAIT with req=4'b0100 pending -> current done issued, no gnt until en=1, then gnt=4'b0100.
REQ-038 Reset mid-WAIT: rstna low for 2 cycles -> all outputs 0, no done pulse; next request launches with tx_tgl 0->1.
REQ-039 Back-to-back: ack arrives same cycle req=4'b0001 rises -> gnt no earlier than cycle after COOL; tx_tgl toggles exactly once per gnt.

Source files
------------

// File: rtl/pulse_cdc_scheduler_pkg.sv
// Shared types and constants for the pulse CDC scheduler.
//   state_e         : scheduler FSM states
//   calc_id_w()     : requester index width, never below 1
//   DEF_*           : default parameter values
package pulse_cdc_scheduler_pkg;

  localparam int unsigned DEF_NREQ        = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_TIMEOUT_CYC = 255;
  localparam int unsigned CNT_W           = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_COOL = 2'd2
  } state_e;

  // max(1, clog2(n))
  function automatic int unsigned calc_id_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pulse_cdc_scheduler_sync_bit.sv
// Multi-flop single-bit synchronizer.
//   clka  : destination clock
//   rstna : async active-low reset, flops clear to 0
//   d     : asynchronous input bit
//   q     : synchronized output (last flop)
module sync_bit
  import pulse_cdc_scheduler_pkg::*;
#(
  parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
  input  logic clka,
  input  logic rstna,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // shift the async bit in at the low end
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clka or negedge rstna) begin
    if (!rstna) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_cdc_scheduler.sv
// Round-robin scheduler sharing one toggle-handshake channel to a
// clkb-domain partner among NREQ clka-domain requesters.
//   clka, rstna : clock, async active-low reset
//   en          : allow new grants (in-flight transfer always completes)
//   req         : level request per requester
//   gnt / done  : one-cycle one-hot launch / completion pulses
//   tx_tgl      : request toggle to clkb, flips once per launch
//   tx_id       : index of the requester owning the channel
//   ack_tgl     : acknowledge toggle from clkb (asynchronous)
//   busy        : channel in WAIT or COOL
//   timeout_err : sticky flag, set when WAIT lasts TIMEOUT_CYC cycles
//   err_clr     : clears timeout_err (a concurrent set wins)
module pulse_cdc_scheduler
  import pulse_cdc_scheduler_pkg::*;
#(
  parameter int unsigned NREQ        = DEF_NREQ,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                           clka,
  input  logic                           rstna,
  input  logic                           en,
  input  logic [NREQ-1:0]                req,
  output logic [NREQ-1:0]                gnt,
  output logic [NREQ-1:0]                done,
  output logic                           tx_tgl,
  output logic [calc_id_w(NREQ)-1:0]     tx_id,
  input  logic                           ack_tgl,
  output logic                           busy,
  output logic                           timeout_err,
  input  logic                           err_clr
);

  localparam int unsigned ID_W = calc_id_w(NREQ);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              tx_tgl_q, tx_tgl_d;
  logic [ID_W-1:0]   tx_id_q, tx_id_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              ack_sync;
  logic              found;
  logic [ID_W-1:0]   pick;
  logic              launch;
  logic              complete;
  logic              timeout_set;

  // ack toggle into the clka domain
  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clka  (clka),
    .rstna (rstna),
    .d     (ack_tgl),
    .q     (ack_sync)
  );

  // round-robin search starting at rr_q, wrapping modulo NREQ
  always_comb begin
    logic [ID_W:0] cand;
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NREQ)) begin
        cand = cand - (ID_W+1)'(NREQ);
      end
      if (!found && req[cand[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[ID_W-1:0];
      end
    end
  end

  assign launch   = (state_q == ST_IDLE) && en && found;
  assign complete = (state_q == ST_WAIT) && (ack_sync == tx_tgl_q);

  // state register
  always_ff @(posedge clka or negedge rstna) begin
    if (!rstna) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (launch)   state_d = ST_WAIT;
      ST_WAIT: if (complete) state_d = ST_COOL;
      ST_COOL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // output / datapath next values
  always_comb begin
    gnt_d       = '0;
    done_d      = '0;
    tx_tgl_d    = tx_tgl_q;
    tx_id_d     = tx_id_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    busy_d      = (state_d != ST_IDLE);
    timeout_set = 1'b0;

    if (launch) begin
      gnt_d[pick] = 1'b1;
      tx_tgl_d    = ~tx_tgl_q;
      tx_id_d     = pick;
      rr_d        = (pick == ID_W'(NREQ - 1)) ? '0 : pick + ID_W'(1);
      cnt_d       = '0;
    end

    if (complete) begin
      done_d[tx_id_q] = 1'b1;
    end

    // counter holds at the threshold so the set keeps re-asserting
    // for the rest of WAIT and beats any err_clr there
    if (state_q == ST_WAIT) begin
      cnt_d       = (cnt_q >= CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      timeout_set = (cnt_d == CNT_MAX);
    end

    err_d = timeout_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clka or negedge rstna) begin
    if (!rstna) begin
      gnt_q    <= '0;
      done_q   <= '0;
      tx_tgl_q <= 1'b0;
      tx_id_q  <= '0;
      rr_q     <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      tx_tgl_q <= tx_tgl_d;
      tx_id_q  <= tx_id_d;
      rr_q     <= rr_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign tx_tgl      = tx_tgl_q;
  assign tx_id       = tx_id_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_pulse_cdc_scheduler.sv
// Directed bench for pulse_cdc_scheduler: NREQ=4, SYNC_STAGES=2, TIMEOUT_CYC=10.
// Inputs are driven and outputs sampled on the falling edge of clka.
module tb_pulse_cdc_scheduler;

  logic       clka = 1'b0;
  logic       rstna;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [3:0] done;
  logic       tx_tgl;
  logic [1:0] tx_id;
  logic       ack_tgl;
  logic       busy;
  logic       timeout_err;
  logic       err_clr;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_tgl = 1'b0;

  pulse_cdc_scheduler #(
    .NREQ        (4),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (10)
  ) dut (
    .clka        (clka),
    .rstna       (rstna),
    .en          (en),
    .req         (req),
    .gnt         (gnt),
    .done        (done),
    .tx_tgl      (tx_tgl),
    .tx_id       (tx_id),
    .ack_tgl     (ack_tgl),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  always #5 clka = ~clka;

  task automatic tick();
    @(negedge clka);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // one edge after a grantable request: grant pulse, toggle flips
  task automatic launch(input logic [3:0] exp_gnt, input logic [1:0] exp_id);
    tick();
    exp_tgl = ~exp_tgl;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("tx_id", 32'(tx_id), 32'(exp_id));
    check("tx_tgl", 32'(tx_tgl), 32'(exp_tgl));
    check("busy_wait", 32'(busy), 32'd1);
  endtask

  // far side echoes after 5 cycles; done 3 edges after echo; IDLE one later
  task automatic finish(input logic [3:0] exp_done, input logic [3:0] req_after);
    tick();
    check("gnt_one_cycle", 32'(gnt), 32'd0);
    repeat (3) tick();
    ack_tgl = exp_tgl;
    tick();
    check("done_early1", 32'(done), 32'd0);
    tick();
    check("done_early2", 32'(done), 32'd0);
    tick();
    check("done", 32'(done), 32'(exp_done));
    check("busy_cool", 32'(busy), 32'd1);
    req = req_after;
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("gnt_after_cool", 32'(gnt), 32'd0);
    check("timeout_clear", 32'(timeout_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rstna = 1'b0; en = 1'b1; req = '0; ack_tgl = 1'b0; err_clr = 1'b0;

    // reset state
    tick(); tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tgl", 32'(tx_tgl), 32'd0);
    check("rst_id", 32'(tx_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    rstna = 1'b1;
    tick();
    check("idle_gnt", 32'(gnt), 32'd0);

    // fairness: all four requesting, each drops on done
    req = 4'b1111;
    launch(4'b0001, 2'd0); finish(4'b0001, 4'b1110);
    launch(4'b0010, 2'd1); finish(4'b0010, 4'b1100);
    launch(4'b0100, 2'd2); finish(4'b0100, 4'b1000);
    launch(4'b1000, 2'd3); finish(4'b1000, 4'b0000);
    req = 4'b1001;
    launch(4'b0001, 2'd0); finish(4'b0001, 4'b1001);
    launch(4'b1000, 2'd3); finish(4'b1000, 4'b1001);
    launch(4'b0001, 2'd0); finish(4'b0001, 4'b1001);
    launch(4'b1000, 2'd3); finish(4'b1000, 4'b0000);

    // single request
    req = 4'b0010;
    launch(4'b0010, 2'd1); finish(4'b0010, 4'b0000);

    // en gating: requester 2 waits while en is low
    req = 4'b0001;
    launch(4'b0001, 2'd0);
    en = 1'b0; req = 4'b0101;
    finish(4'b0001, 4'b0100);
    repeat (3) begin
      tick();
      check("en_gnt_blocked", 32'(gnt), 32'd0);
      check("en_busy", 32'(busy), 32'd0);
    end
    en = 1'b1;
    launch(4'b0100, 2'd2); finish(4'b0100, 4'b0000);

    // back-to-back: new request rises in the completion cycle
    req = 4'b0010;
    launch(4'b0010, 2'd1);
    repeat (4) tick();
    ack_tgl = exp_tgl;
    tick();
    check("b2b_done_early", 32'(done), 32'd0);
    tick();
    req = 4'b0011;
    tick();
    check("b2b_done", 32'(done), 32'b0010);
    check("b2b_gnt_cool", 32'(gnt), 32'd0);
    req = 4'b0001;
    tick();
    check("b2b_gnt_idle", 32'(gnt), 32'd0);
    check("b2b_tgl_hold", 32'(tx_tgl), 32'(exp_tgl));
    launch(4'b0001, 2'd0); finish(4'b0001, 4'b0000);

    // timeout: no ack for 10 WAIT cycles
    req = 4'b1000;
    launch(4'b1000, 2'd3);
    repeat (9) tick();
    check("to_not_yet", 32'(timeout_err), 32'd0);
    tick();
    check("to_set", 32'(timeout_err), 32'd1);
    check("to_busy", 32'(busy), 32'd1);
    err_clr = 1'b1;
    tick();
    check("to_set_wins", 32'(timeout_err), 32'd1);
    check("to_no_done", 32'(done), 32'd0);
    err_clr = 1'b0;
    ack_tgl = exp_tgl;
    tick(); tick(); tick();
    check("to_late_done", 32'(done), 32'b1000);
    req = 4'b0000;
    tick();
    check("to_sticky", 32'(timeout_err), 32'd1);
    check("to_idle", 32'(busy), 32'd0);
    err_clr = 1'b1;
    tick();
    check("to_cleared", 32'(timeout_err), 32'd0);
    err_clr = 1'b0;

    // reset mid-WAIT abandons the transfer
    req = 4'b0001;
    launch(4'b0001, 2'd0);
    tick(); tick();
    rstna = 1'b0; ack_tgl = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_tgl", 32'(tx_tgl), 32'd0);
    check("mrst_id", 32'(tx_id), 32'd0);
    tick();
    check("mrst_done1", 32'(done), 32'd0);
    tick();
    check("mrst_done2", 32'(done), 32'd0);
    check("mrst_gnt", 32'(gnt), 32'd0);
    rstna = 1'b1;
    exp_tgl = 1'b0;
    launch(4'b0001, 2'd0); finish(4'b0001, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
